// File: rtl/vend_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : vend_pkg                                                        |
// | Desc     : Shared states, coin units and price lookup for the vend block.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } vend_state_t;

    localparam logic [1:0] COIN5_UNITS  = 2'd1;
    localparam logic [1:0] COIN10_UNITS = 2'd2;

    // Wide enough for 16 products at up to 16 bits per price.
    localparam int c_PRICE_VEC_W = 256;
    localparam int c_PRICE_W     = 16;

    function automatic logic [c_PRICE_W-1:0] price_of(
        input logic [c_PRICE_VEC_W-1:0] prices,
        input int                       cw,
        input int                       idx
    );
        logic [c_PRICE_VEC_W-1:0] v;
        v = prices >> (idx * cw);
        v = v & ((c_PRICE_VEC_W'(1) << cw) - c_PRICE_VEC_W'(1));
        return v[c_PRICE_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/vend_credit_acc.sv
// +----------------------------------------------------------------------------+
// | Module   : vend_credit_acc                                                 |
// | Desc     : Credit register with overflow-rejecting add and subtract port.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module vend_credit_acc #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_add_en,
    input  logic [1:0]    i_inc,
    input  logic          i_sub_en,
    input  logic [CW-1:0] i_sub_val,
    output logic [CW-1:0] o_credit,
    output logic [CW-1:0] o_sum_credit,
    output logic          o_ovf
);

    logic [CW-1:0] r_credit;
    logic [CW:0]   w_sum;

    // One extra bit holds credit+3 for any CW >= 2.
    assign w_sum        = {1'b0, r_credit} + (CW+1)'(i_inc);
    assign o_ovf        = i_add_en && (i_inc != 2'd0) && w_sum[CW];
    assign o_sum_credit = (i_add_en && !o_ovf) ? w_sum[CW-1:0] : r_credit;
    assign o_credit     = r_credit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit <= '0;
        end else if (i_sub_en) begin
            r_credit <= r_credit - i_sub_val;
        end else if (i_add_en) begin
            r_credit <= o_sum_credit;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vend_ctrl_multi.sv
// +----------------------------------------------------------------------------+
// | Module   : vend_ctrl_multi                                                 |
// | Desc     : Multi-product vending controller; optional idle-coin timeout    |
// |            enabled with macro VEND_TIMEOUT_EN.                             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int                  NPROD   = 4,
    parameter int                  CW      = 4,
    parameter logic [NPROD*CW-1:0] PRICES  = {4'd5, 4'd4, 4'd3, 4'd2},
    parameter int                  TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPROD-1:0] sel,
    input  logic             coin_5,
    input  logic             coin_10,
    input  logic             cancel,
    output logic [NPROD-1:0] dispense,
    output logic             change_5,
    output logic             coin_rej,
    output logic             busy,
    output logic [CW-1:0]    credit
);

    localparam int                       c_IDX_W      = (NPROD > 1) ? $clog2(NPROD) : 1;
    localparam logic [c_PRICE_VEC_W-1:0] c_PRICES_EXT = c_PRICE_VEC_W'(PRICES);

    vend_state_t        r_state;
    vend_state_t        w_next;
    logic [c_IDX_W-1:0] r_prod;
    logic [CW-1:0]      r_price;
    logic [c_IDX_W-1:0] w_sel_idx;
    logic [1:0]         w_inc;
    logic               w_add_en;
    logic               w_sub_en;
    logic [CW-1:0]      w_sub_val;
    logic [CW-1:0]      w_new_credit;
    logic               w_ovf;
    logic               w_credited;
    logic               w_timeout;
    logic [NPROD-1:0]   w_dispense;
    logic               w_change_5;
    logic               w_coin_rej;
    logic               w_busy;

    always_comb begin
        w_sel_idx = '0;
        for (int i = NPROD - 1; i >= 0; i--) begin
            if (sel[i]) w_sel_idx = c_IDX_W'(i);
        end
    end

    assign w_inc      = (coin_5 ? COIN5_UNITS : 2'd0) + (coin_10 ? COIN10_UNITS : 2'd0);
    assign w_add_en   = (r_state == COLLECT);
    assign w_sub_en   = (r_state == DISPENSE) || (r_state == CHANGE);
    assign w_sub_val  = (r_state == DISPENSE) ? r_price : CW'(1);
    assign w_credited = w_add_en && (w_inc != 2'd0) && !w_ovf;

    vend_credit_acc #(
        .CW (CW)
    ) u_credit_acc (
        .clk          (clk),
        .rst          (rst),
        .i_add_en     (w_add_en),
        .i_inc        (w_inc),
        .i_sub_en     (w_sub_en),
        .i_sub_val    (w_sub_val),
        .o_credit     (credit),
        .o_sum_credit (w_new_credit),
        .o_ovf        (w_ovf)
    );

`ifdef VEND_TIMEOUT_EN
    localparam int c_TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [c_TMO_W-1:0] r_tmo_cnt;

    assign w_timeout = (r_state == COLLECT) && !w_credited &&
                       (r_tmo_cnt == c_TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == COLLECT) && !w_credited && !w_timeout) begin
            r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
        end else begin
            r_tmo_cnt <= '0;
        end
    end
`else
    // TIMEOUT has no effect in this build; the expression is always false.
    assign w_timeout = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_prod   <= '0;
            r_price  <= '0;
            dispense <= '0;
            change_5 <= 1'b0;
            coin_rej <= 1'b0;
            busy     <= 1'b0;
        end else begin
            r_state  <= w_next;
            if ((r_state == IDLE) && (|sel)) begin
                r_prod  <= w_sel_idx;
                r_price <= CW'(price_of(c_PRICES_EXT, CW, 32'(w_sel_idx)));
            end
            dispense <= w_dispense;
            change_5 <= w_change_5;
            coin_rej <= w_coin_rej;
            busy     <= w_busy;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (|sel) w_next = COLLECT;
            end
            COLLECT: begin
                // A coin in the same cycle as cancel is credited, then refunded.
                if (cancel || w_timeout) begin
                    w_next = (w_new_credit != '0) ? CHANGE : IDLE;
                end else if (w_new_credit >= r_price) begin
                    w_next = DISPENSE;
                end
            end
            DISPENSE: begin
                w_next = (credit != r_price) ? CHANGE : IDLE;
            end
            CHANGE: begin
                if (credit <= CW'(1)) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_dispense = '0;
        if (r_state == DISPENSE) w_dispense = NPROD'(1) << r_prod;
        w_change_5 = (r_state == CHANGE);
        w_coin_rej = ((r_state == COLLECT) && w_ovf) ||
                     ((r_state == CHANGE) && (coin_5 || coin_10));
        w_busy     = (w_next != IDLE);
    end

endmodule

`default_nettype wire
